clocks_en_ctrl: RTL and testbench

//  Synthesizable controller for a divided clock-enable domain.
//  - Generates a clk_en pulse train from a programmed divider (same div semantics as clock-enable generation).
//  - Sequences the downstream domain reset around it: reset held while the enable runs, released, then re-asserted on stop.
//  - Sits between the TB/CSR config path and any block gated by clk_en/dom_reset_n.

---
 rtl/clocks_en_ctrl_pkg.sv | 19 +
 rtl/clocks_en_div.sv | 66 ++++++
 rtl/clocks_en_ctrl.sv | 130 +++++++++++++
 tb/tb_clocks_en_ctrl.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/clocks_en_ctrl_pkg.sv
// Shared types and defaults for the divided clock-enable domain controller.
package clocks_en_ctrl_pkg;

  typedef enum logic [1:0] {
    OFF      = 2'd0,
    RST_HOLD = 2'd1,
    RUN      = 2'd2,
    STOP     = 2'd3
  } clocks_en_state_t;

  localparam int DEF_DIV_W    = 8;
  localparam int DEF_RST_CYC  = 16;
  localparam int DEF_STOP_CYC = 4;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/clocks_en_div.sv
// Phase counter producing the clk_en pulse train, with glitch-free divider change at wrap.
module clocks_en_div
  import clocks_en_ctrl_pkg::*;
#(
  parameter int DIV_W = DEF_DIV_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             active,
  input  logic             load,
  input  logic [DIV_W-1:0] load_div,
  input  logic             pend_req,
  input  logic [DIV_W-1:0] pend_div,
  input  logic             pend_clr,
  output logic             clk_en
);

  logic [DIV_W-1:0] ph_r;
  logic [DIV_W-1:0] div_q_r;
  logic [DIV_W-1:0] div_pend_r;
  logic             pend_r;
  logic             wrap_s;

  assign wrap_s = (ph_r == (div_q_r - DIV_W'(1)));
  assign clk_en = active & wrap_s;

  // Phase counter and active divide ratio; a pending ratio only lands on a wrap.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ph_r    <= '0;
      div_q_r <= '0;
    end else if (load) begin
      ph_r    <= '0;
      div_q_r <= load_div;
    end else if (!active) begin
      ph_r    <= '0;
    end else if (wrap_s) begin
      ph_r    <= '0;
      if (pend_r) begin
        div_q_r <= div_pend_r;
      end else begin
        div_q_r <= div_q_r;
      end
    end else begin
      ph_r    <= ph_r + DIV_W'(1);
    end
  end

  // Pending ratio: a newer request overwrites an older one still waiting for the wrap.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pend_r     <= 1'b0;
      div_pend_r <= '0;
    end else if (pend_clr || load) begin
      pend_r     <= 1'b0;
    end else if (pend_req) begin
      pend_r     <= 1'b1;
      div_pend_r <= pend_div;
    end else if (active && wrap_s) begin
      pend_r     <= 1'b0;
    end else begin
      pend_r     <= pend_r;
    end
  end

endmodule

// File: rtl/clocks_en_ctrl.sv
// Divided clock-enable controller: sequences downstream reset around a programmable clk_en.
module clocks_en_ctrl
  import clocks_en_ctrl_pkg::*;
#(
  parameter int DIV_W    = DEF_DIV_W,
  parameter int RST_CYC  = DEF_RST_CYC,
  parameter int STOP_CYC = DEF_STOP_CYC
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic             cfg_enable,
  output logic             clk_en,
  output logic             dom_reset_n,
  output logic [1:0]       state,
  output logic             running
);

  localparam int PCNT_W = $clog2(max_int(RST_CYC, STOP_CYC) + 1);

  clocks_en_state_t  state_r;
  clocks_en_state_t  state_nxt_s;
  logic [PCNT_W-1:0] pcnt_r;
  logic [PCNT_W-1:0] pcnt_nxt_s;
  logic              accept_s;
  logic              go_s;
  logic              load_s;
  logic              pend_req_s;
  logic              pend_clr_s;
  logic              active_s;
  logic              clk_en_s;

  assign cfg_ready   = (state_r == OFF) || (state_r == RUN);
  assign accept_s    = cfg_valid & cfg_ready;
  assign go_s        = cfg_enable && (cfg_div != '0);
  assign active_s    = (state_r != OFF);
  assign clk_en      = clk_en_s;
  assign dom_reset_n = (state_r == RUN);
  assign running     = (state_r == RUN);
  assign state       = state_r;

  clocks_en_div #(
    .DIV_W(DIV_W)
  ) u_div (
    .clk      (clk),
    .reset    (reset),
    .active   (active_s),
    .load     (load_s),
    .load_div (cfg_div),
    .pend_req (pend_req_s),
    .pend_div (cfg_div),
    .pend_clr (pend_clr_s),
    .clk_en   (clk_en_s)
  );

  // State and pulse-counter registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= OFF;
      pcnt_r  <= '0;
    end else begin
      state_r <= state_nxt_s;
      pcnt_r  <= pcnt_nxt_s;
    end
  end

  // Next-state logic; pcnt counts clk_en pulses within RST_HOLD and STOP.
  always_comb begin
    state_nxt_s = state_r;
    pcnt_nxt_s  = pcnt_r;
    load_s      = 1'b0;
    pend_req_s  = 1'b0;
    pend_clr_s  = 1'b0;
    case (state_r)
      OFF: begin
        if (accept_s && go_s) begin
          load_s      = 1'b1;
          pcnt_nxt_s  = '0;
          state_nxt_s = RST_HOLD;
        end else begin
          state_nxt_s = OFF;
        end
      end
      RST_HOLD: begin
        if (clk_en_s) begin
          if (pcnt_r == PCNT_W'(RST_CYC - 1)) begin
            pcnt_nxt_s  = '0;
            state_nxt_s = RUN;
          end else begin
            pcnt_nxt_s  = pcnt_r + PCNT_W'(1);
          end
        end else begin
          pcnt_nxt_s = pcnt_r;
        end
      end
      RUN: begin
        if (accept_s) begin
          if (go_s) begin
            pend_req_s = 1'b1;
          end else begin
            pend_clr_s  = 1'b1;
            pcnt_nxt_s  = '0;
            state_nxt_s = STOP;
          end
        end else begin
          state_nxt_s = RUN;
        end
      end
      STOP: begin
        if (clk_en_s) begin
          if (pcnt_r == PCNT_W'(STOP_CYC - 1)) begin
            pcnt_nxt_s  = '0;
            state_nxt_s = OFF;
          end else begin
            pcnt_nxt_s  = pcnt_r + PCNT_W'(1);
          end
        end else begin
          pcnt_nxt_s = pcnt_r;
        end
      end
      default: begin
        pcnt_nxt_s  = '0;
        state_nxt_s = OFF;
      end
    endcase
  end

endmodule

// File: tb/tb_clocks_en_ctrl.sv
// Directed bench for clocks_en_ctrl with RST_CYC=4, STOP_CYC=2.
module tb_clocks_en_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [7:0] cfg_div;
  logic       cfg_enable;
  logic       clk_en;
  logic       dom_reset_n;
  logic [1:0] state;
  logic       running;

  int total = 0;
  int bad   = 0;

  clocks_en_ctrl #(
    .DIV_W(8),
    .RST_CYC(4),
    .STOP_CYC(2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_div    (cfg_div),
    .cfg_enable (cfg_enable),
    .clk_en     (clk_en),
    .dom_reset_n(dom_reset_n),
    .state      (state),
    .running    (running)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_state"}, {6'd0, state}, 8'd0);
    chk({tag, "_clk_en"}, {7'd0, clk_en}, 8'd0);
    chk({tag, "_dom"}, {7'd0, dom_reset_n}, 8'd0);
    chk({tag, "_ready"}, {7'd0, cfg_ready}, 8'd1);
    chk({tag, "_running"}, {7'd0, running}, 8'd0);
  endtask

  initial begin
    reset      = 1'b0;
    cfg_valid  = 1'b0;
    cfg_div    = 8'd0;
    cfg_enable = 1'b0;

    // 1. reset
    step();
    step();
    chk_idle("rst");
    reset = 1'b1;
    step();
    chk_idle("post_rst");

    // 2. div=3 start: pulses at 3,6,9,12, RUN at 13
    cfg_valid = 1'b1; cfg_div = 8'd3; cfg_enable = 1'b1;
    step();
    cfg_valid = 1'b0;
    chk("d3_ready_hold", {7'd0, cfg_ready}, 8'd0);
    for (int c = 1; c <= 13; c++) begin
      chk($sformatf("d3_clk_en_c%0d", c), {7'd0, clk_en}, (c % 3 == 0) ? 8'd1 : 8'd0);
      chk($sformatf("d3_dom_c%0d", c), {7'd0, dom_reset_n}, (c >= 13) ? 8'd1 : 8'd0);
      chk($sformatf("d3_state_c%0d", c), {6'd0, state}, (c >= 13) ? 8'd2 : 8'd1);
      if (c < 13) step();
    end
    chk("d3_running", {7'd0, running}, 8'd1);

    // 5. stop from RUN div=3: two more pulses then OFF
    cfg_valid = 1'b1; cfg_enable = 1'b0;
    step();
    cfg_valid = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      chk($sformatf("stop_clk_en_k%0d", k), {7'd0, clk_en}, (k == 2 || k == 5) ? 8'd1 : 8'd0);
      chk($sformatf("stop_dom_k%0d", k), {7'd0, dom_reset_n}, 8'd0);
      chk($sformatf("stop_state_k%0d", k), {6'd0, state}, (k < 6) ? 8'd3 : 8'd0);
      chk($sformatf("stop_ready_k%0d", k), {7'd0, cfg_ready}, (k < 6) ? 8'd0 : 8'd1);
      if (k < 6) step();
    end
    step();
    chk("stop_off_clk_en", {7'd0, clk_en}, 8'd0);

    // 3. div=1: clk_en constant from cycle 1, RUN at 5
    cfg_valid = 1'b1; cfg_div = 8'd1; cfg_enable = 1'b1;
    step();
    cfg_valid = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      chk($sformatf("d1_clk_en_c%0d", c), {7'd0, clk_en}, 8'd1);
      chk($sformatf("d1_state_c%0d", c), {6'd0, state}, (c < 5) ? 8'd1 : 8'd2);
      chk($sformatf("d1_dom_c%0d", c), {7'd0, dom_reset_n}, (c < 5) ? 8'd0 : 8'd1);
      if (c < 5) step();
    end

    // 4. change to div=4 (lands at next wrap, cycle 6), then div=2 requested at ph=1 (cycle 8)
    cfg_valid = 1'b1; cfg_div = 8'd4; cfg_enable = 1'b1;
    step();
    cfg_valid = 1'b0;
    chk("chg_c6_clk_en", {7'd0, clk_en}, 8'd1);
    step();
    chk("chg_c7_clk_en", {7'd0, clk_en}, 8'd0);
    step();
    chk("chg_c8_clk_en", {7'd0, clk_en}, 8'd0);
    cfg_valid = 1'b1; cfg_div = 8'd2;
    step();
    cfg_valid = 1'b0;
    for (int c = 9; c <= 16; c++) begin
      chk($sformatf("chg_clk_en_c%0d", c), {7'd0, clk_en}, (c >= 10 && c % 2 == 0) ? 8'd1 : 8'd0);
      chk($sformatf("chg_state_c%0d", c), {6'd0, state}, 8'd2);
      if (c < 16) step();
    end

    // 6a. reset asserted in RUN
    reset = 1'b0;
    step();
    chk_idle("mid_rst");
    reset = 1'b1;
    step();

    // 6b. request held through RST_HOLD (div=2, pulses 2,4,6,8) only taken in RUN at 9
    cfg_valid = 1'b1; cfg_div = 8'd2; cfg_enable = 1'b1;
    step();
    cfg_enable = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      chk($sformatf("hold_state_c%0d", c), {6'd0, state}, (c < 9) ? 8'd1 : 8'd2);
      chk($sformatf("hold_ready_c%0d", c), {7'd0, cfg_ready}, (c < 9) ? 8'd0 : 8'd1);
      if (c < 9) step();
    end
    step();
    cfg_valid = 1'b0;
    chk("hold_stop_state", {6'd0, state}, 8'd3);
    chk("hold_stop_dom", {7'd0, dom_reset_n}, 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
